// File: rtl/fmac_result_checker.sv
// Result checker for FloPoCo fmul/fadd cores: delays expected values by the core latency and compares them with R.
// Optional macro FMAC_CHECK_FIRSTERR_EN adds first-failure capture outputs (index, r, expected).
module fmac_result_checker #(
  parameter int WE      = 8,
  parameter int WF      = 23,
  parameter int LATENCY = 4,
  parameter int N_OPS   = 16,
  parameter int CNT_W   = 16,
  parameter int TOL_ULP = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 issue_valid,
  input  logic [WE+WF+2:0]     issue_expected,
  input  logic [WE+WF+2:0]     r,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     checked_count,
  output logic [CNT_W-1:0]     err_count
`ifdef FMAC_CHECK_FIRSTERR_EN
  ,
  output logic [CNT_W-1:0]     first_err_idx,
  output logic [WE+WF+2:0]     first_err_r,
  output logic [WE+WF+2:0]     first_err_exp
`endif
);

  localparam int W   = WE + WF + 3;
  localparam int MW  = WE + WF;
  localparam int ICW = $clog2(N_OPS + 1);
  localparam logic [MW-1:0]  TOL_V     = MW'(TOL_ULP);
  localparam logic [ICW-1:0] LAST_IDX  = ICW'(N_OPS - 1);
  localparam logic [ICW-1:0] FULL_IDX  = ICW'(N_OPS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [ICW-1:0]       issue_cnt_q, issue_cnt_d;
  logic                 accept;
  logic                 clr_cnt;

  logic [LATENCY-1:0]           dl_v_q, dl_v_d;
  logic [LATENCY-1:0][W-1:0]    dl_e_q, dl_e_d;
  logic                         any_v;

  logic [W-1:0]   tail_e;
  logic           tail_v;
  logic [1:0]     exc_e, exc_r;
  logic           sign_eq;
  logic [MW-1:0]  mag_e, mag_r, mag_diff;
  logic           cmp_fail;

  logic           cmp_v_q, cmp_v_d;
  logic           cmp_fail_q, cmp_fail_d;
  logic [CNT_W-1:0] checked_q, checked_d;
  logic [CNT_W-1:0] err_q, err_d;

  // Delay line: stage 0 captures accepted issues, later stages shift every cycle.
  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_dl
      if (gi == 0) begin : g_head
        assign dl_v_d[gi] = accept;
        assign dl_e_d[gi] = issue_expected;
      end else begin : g_body
        assign dl_v_d[gi] = dl_v_q[gi-1];
        assign dl_e_d[gi] = dl_e_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      dl_v_q <= '0;
    end else begin
      dl_v_q <= dl_v_d;
    end
    dl_e_q <= dl_e_d;
  end

  assign any_v  = |dl_v_q;
  assign tail_v = dl_v_q[LATENCY-1];
  assign tail_e = dl_e_q[LATENCY-1];

  always_comb begin
    exc_e    = tail_e[W-1:W-2];
    exc_r    = r[W-1:W-2];
    sign_eq  = (tail_e[W-3] == r[W-3]);
    mag_e    = tail_e[MW-1:0];
    mag_r    = r[MW-1:0];
    mag_diff = (mag_r >= mag_e) ? (mag_r - mag_e) : (mag_e - mag_r);
    cmp_fail = 1'b0;
    if (exc_e != exc_r) begin
      cmp_fail = 1'b1;
    end else begin
      // zero and NaN compare equal regardless of sign and payload
      case (exc_e)
        2'b10:   cmp_fail = !sign_eq;
        2'b01:   cmp_fail = !sign_eq || (mag_diff > TOL_V);
        default: cmp_fail = 1'b0;
      endcase
    end
  end

  assign cmp_v_d    = tail_v;
  assign cmp_fail_d = cmp_fail;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_v_q    <= 1'b0;
      cmp_fail_q <= 1'b0;
    end else begin
      cmp_v_q    <= cmp_v_d;
      cmp_fail_q <= cmp_fail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    accept      = 1'b0;
    clr_cnt     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_RUN;
          issue_cnt_d = '0;
          clr_cnt     = 1'b1;
        end
      end
      S_RUN: begin
        if (issue_valid && (issue_cnt_q != FULL_IDX)) begin
          accept      = 1'b1;
          issue_cnt_d = issue_cnt_q + ICW'(1);
          if (issue_cnt_q == LAST_IDX) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The compare register drains into the counters on this same edge,
        // so DONE and the final counts become visible together.
        if (!any_v) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  always_comb begin
    checked_d = checked_q;
    err_d     = err_q;
    if (clr_cnt) begin
      checked_d = '0;
      err_d     = '0;
    end else if (cmp_v_q) begin
      if (checked_q != '1) begin
        checked_d = checked_q + CNT_W'(1);
      end
      if (cmp_fail_q && (err_q != '1)) begin
        err_d = err_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      checked_q <= '0;
      err_q     <= '0;
    end else begin
      checked_q <= checked_d;
      err_q     <= err_d;
    end
  end

  assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign pass          = done && (err_q == '0);
  assign mismatch      = cmp_v_q && cmp_fail_q;
  assign checked_count = checked_q;
  assign err_count     = err_q;

`ifdef FMAC_CHECK_FIRSTERR_EN
  logic [W-1:0]     cmp_r_q, cmp_e_q;
  logic             fe_seen_q, fe_seen_d;
  logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
  logic [W-1:0]     fe_r_q, fe_r_d;
  logic [W-1:0]     fe_e_q, fe_e_d;

  always_ff @(posedge clk) begin
    cmp_r_q <= r;
    cmp_e_q <= tail_e;
  end

  // The op index is the number of compares already counted in this run.
  always_comb begin
    fe_seen_d = fe_seen_q;
    fe_idx_d  = fe_idx_q;
    fe_r_d    = fe_r_q;
    fe_e_d    = fe_e_q;
    if (clr_cnt) begin
      fe_seen_d = 1'b0;
      fe_idx_d  = '0;
      fe_r_d    = '0;
      fe_e_d    = '0;
    end else if (cmp_v_q && cmp_fail_q && !fe_seen_q) begin
      fe_seen_d = 1'b1;
      fe_idx_d  = checked_q;
      fe_r_d    = cmp_r_q;
      fe_e_d    = cmp_e_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fe_seen_q <= 1'b0;
      fe_idx_q  <= '0;
      fe_r_q    <= '0;
      fe_e_q    <= '0;
    end else begin
      fe_seen_q <= fe_seen_d;
      fe_idx_q  <= fe_idx_d;
      fe_r_q    <= fe_r_d;
      fe_e_q    <= fe_e_d;
    end
  end

  assign first_err_idx = fe_idx_q;
  assign first_err_r   = fe_r_q;
  assign first_err_exp = fe_e_q;
`endif

endmodule

// File: tb/tb_fmac_result_checker.sv
// Self-checking bench for fmac_result_checker: directed scenarios plus random runs against a per-op scoreboard.
module tb_fmac_result_checker;

  localparam int WE  = 8;
  localparam int WF  = 23;
  localparam int W   = WE + WF + 3;
  localparam int L   = 4;
  localparam int N   = 4;
  localparam int CW  = 16;
  localparam int TOL = 1;

  localparam logic [W-1:0] ONE     = 34'h1_3F80_0000;
  localparam logic [W-1:0] TWO     = 34'h1_4000_0000;
  localparam logic [W-1:0] ZERO_P  = 34'h0_0000_0000;
  localparam logic [W-1:0] ZERO_N  = 34'h0_8000_0000;
  localparam logic [W-1:0] NAN_A   = 34'h3_0000_0001;
  localparam logic [W-1:0] NAN_B   = 34'h3_FFFF_FFFF;
  localparam logic [W-1:0] INF_P   = 34'h2_0000_0000;
  localparam logic [W-1:0] INF_N   = 34'h2_8000_0000;

  logic          clk = 1'b0;
  logic          reset, start, issue_valid;
  logic [W-1:0]  issue_expected, r;
  logic          busy, done, pass, mismatch;
  logic [CW-1:0] checked_count, err_count;
`ifdef FMAC_CHECK_FIRSTERR_EN
  logic [CW-1:0] first_err_idx;
  logic [W-1:0]  first_err_r, first_err_exp;
`endif

  always #5 clk = ~clk;

  fmac_result_checker #(
    .WE(WE), .WF(WF), .LATENCY(L), .N_OPS(N), .CNT_W(CW), .TOL_ULP(TOL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .issue_valid(issue_valid),
    .issue_expected(issue_expected), .r(r),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .checked_count(checked_count), .err_count(err_count)
`ifdef FMAC_CHECK_FIRSTERR_EN
    , .first_err_idx(first_err_idx), .first_err_r(first_err_r), .first_err_exp(first_err_exp)
`endif
  );

  // Scoreboard: one entry per accepted op of the current run, with the cycle
  // its mismatch pulse is due and whether it should fail.
  typedef struct { int due; bit fail; } op_t;
  op_t ops[$];
  bit  m_active;
  int  cyc;
  int  n_vec;
  int  n_err;
  logic [W-1:0] r_sched [int];

  function automatic bit ref_fail(input logic [W-1:0] e, input logic [W-1:0] a);
    longint de, da, d;
    if (e[W-1:W-2] != a[W-1:W-2]) return 1'b1;
    if (e[W-1:W-2] == 2'b00 || e[W-1:W-2] == 2'b11) return 1'b0;
    if (e[W-3] != a[W-3]) return 1'b1;
    if (e[W-1:W-2] == 2'b10) return 1'b0;
    de = longint'(e[W-4:0]);
    da = longint'(a[W-4:0]);
    d  = (de > da) ? de - da : da - de;
    return d > TOL;
  endfunction

  function automatic bit m_done();
    return m_active && ops.size() == N && ops[N-1].due < cyc;
  endfunction

  function automatic int m_checked();
    int n = 0;
    foreach (ops[i]) if (ops[i].due < cyc) n++;
    return n;
  endfunction

  function automatic int m_errs();
    int n = 0;
    foreach (ops[i]) if (ops[i].due < cyc && ops[i].fail) n++;
    return n;
  endfunction

  function automatic bit m_mis();
    foreach (ops[i]) if (ops[i].due == cyc && ops[i].fail) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, got, want);
    end
  endtask

  function automatic logic [W-1:0] rnd_w();
    return W'({$urandom(), $urandom()});
  endfunction

  // One clock: apply inputs, update the scoreboard, then check every output.
  task automatic tick(input bit rs, input bit st, input bit iv,
                      input logic [W-1:0] ie, input logic [W-1:0] rop);
    int c;
    c = cyc;
    reset          = rs;
    start          = st;
    issue_valid    = iv;
    issue_expected = ie;
    r              = r_sched.exists(c) ? r_sched[c] : rnd_w();
    if (iv) r_sched[c+L] = rop;
    if (rs) begin
      m_active = 1'b0;
      ops.delete();
    end else if (st && !(m_active && !m_done())) begin
      m_active = 1'b1;
      ops.delete();
    end else if (iv && m_active && !m_done() && ops.size() < N) begin
      ops.push_back('{due: c + L + 1, fail: ref_fail(ie, rop)});
    end
    @(posedge clk);
    #1;
    cyc = c + 1;
    chk("busy",     busy,          m_active && !m_done());
    chk("done",     done,          m_done());
    chk("pass",     pass,          m_done() && m_errs() == 0);
    chk("mismatch", mismatch,      m_mis());
    chk("checked",  checked_count, m_checked());
    chk("err",      err_count,     m_errs());
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, 0, rnd_w(), rnd_w());
  endtask

  // Drain with random (ignored) issue pulses; bounded wait for done.
  task automatic drain();
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1) break;
      tick(0, 0, 1'($urandom_range(0, 1)), rnd_w(), rnd_w());
    end
    chk("drain_done", done, 1'b1);
  endtask

  task automatic rnd_pair(output logic [W-1:0] e, output logic [W-1:0] a);
    logic [W-4:0] mag;
    e   = rnd_w();
    mag = e[W-4:0];
    a   = e;
    case ($urandom_range(0, 6))
      0: a = e;
      1: a[W-4:0] = mag + 1'b1;
      2: a[W-4:0] = mag - 1'b1;
      3: a[W-4:0] = mag + 2'd2;
      4: a[W-3]   = ~e[W-3];
      5: a[W-1:W-2] = 2'($urandom_range(0, 3));
      default: a[W-4:0] = W'($urandom());
    endcase
  endtask

  initial begin
    logic [W-1:0] e, a;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    m_active = 1'b0;
    reset = 1'b1; start = 1'b0; issue_valid = 1'b0; issue_expected = '0; r = '0;

    tick(1, 0, 0, '0, '0);
    tick(1, 0, 0, '0, '0);
    // issue pulses in IDLE are ignored
    for (int k = 0; k < 3; k++) tick(0, 0, 1, ONE, TWO);

    // matching run
    tick(0, 1, 0, '0, '0);
    for (int k = 0; k < N; k++) tick(0, 0, 1, ONE, ONE);
    drain();
    chk("match_pass", pass, 1'b1);

    // single mismatch on op 2
    tick(0, 1, 0, '0, '0);
    for (int k = 0; k < N; k++) tick(0, 0, 1, ONE, (k == 2) ? TWO : ONE);
    drain();
    chk("single_err", err_count, 1);
`ifdef FMAC_CHECK_FIRSTERR_EN
    chk("first_err_idx", first_err_idx, 2);
    chk("first_err_r",   first_err_r,   TWO);
    chk("first_err_exp", first_err_exp, ONE);
`endif

    // exceptions, with gaps between issues
    tick(0, 1, 0, '0, '0);
    tick(0, 0, 1, ZERO_P, ZERO_N);
    idle(1);
    tick(0, 0, 1, NAN_A, NAN_B);
    tick(0, 0, 1, INF_P, INF_N);
    idle(2);
    tick(0, 0, 1, INF_N, INF_N);
    drain();

    // tolerance of one ulp
    tick(0, 1, 0, '0, '0);
    tick(0, 0, 1, ONE, 34'h1_3F7F_FFFF);
    tick(0, 0, 1, ONE, 34'h1_3F80_0002);
    tick(0, 0, 1, ONE, 34'h1_3F80_0001);
    tick(0, 0, 1, ONE, 34'h1_BF80_0000);
    drain();

    // six pulses, then start during DRAIN
    tick(0, 1, 0, '0, '0);
    for (int k = 0; k < 6; k++) tick(0, 0, 1, ONE, (k == 5) ? TWO : ONE);
    tick(0, 1, 0, '0, '0);
    drain();

    // reset with ops in flight
    tick(0, 1, 0, '0, '0);
    for (int k = 0; k < N; k++) tick(0, 0, 1, ONE, TWO);
    tick(0, 0, 0, '0, '0);
    tick(1, 0, 0, '0, '0);
    idle(8);

    // random runs
    for (int run = 0; run < 12; run++) begin
      tick(0, 1, 0, rnd_w(), rnd_w());
      for (int k = 0; k < 24 && busy === 1'b1 && ops.size() < N; k++) begin
        rnd_pair(e, a);
        tick(0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 7), e, a);
      end
      drain();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fmac_result_checker.md
Name: fmac_result_checker

Overview:
- Response-side counterpart to the one-hot-FSM operand driver that feeds the fmul/fadd cores.
- Receives expected results at issue time and delays them by the core's fixed pipeline latency.
- Compares each delayed expected value against the core's R output in FloPoCo format (2-bit exception, sign, wE exponent, wF fraction).
- Counts checks and mismatches, and reports pass/fail when a run of N_OPS operations has drained.

Parameters:
- WE, 8, exponent width wE
- WF, 23, fraction width wF
- LATENCY, 4, cycles from operand issue to valid R at the core output; must be >= 1
- N_OPS, 16, operations per run
- CNT_W, 16, width of the count outputs
- TOL_ULP, 0, allowed |difference| of {exp,frac} for normal numbers

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a run; clears counters
- issue_valid  in  1  an operation is issued to the core this cycle
- issue_expected  in  WE+WF+3  expected R for the issued operation
- r  in  WE+WF+3  core result output (fmulN_r / faddN_r)
- busy  out  1  state is RUN or DRAIN
- done  out  1  run complete; held until next start
- pass  out  1  done and err_count == 0
- mismatch  out  1  one-cycle pulse per failed compare
- checked_count  out  CNT_W  compares performed
- err_count  out  CNT_W  compares failed

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; delay line valid bits cleared.
  - All outputs 0.
  - Reset mid-run aborts the run; no partial results are retained.
- Delay line: LATENCY stages, each holding {v, exp}.
  - Stage 0 loads {issue_valid & (state==RUN), issue_expected}.
  - Each stage shifts by one every cycle.
  - The tail (stage LATENCY-1) aligns with r on the same cycle.
- Compare, evaluated when the tail v=1 (field exc = bits [WE+WF+2:WE+WF+1]):
  - exc differ -> fail.
  - exc=00 (zero): pass; sign and payload are ignored.
  - exc=11 (NaN): pass; sign and payload are ignored.
  - exc=10 (inf): pass iff signs equal.
  - exc=01 (normal): pass iff signs equal and |{exp,frac}_r - {exp,frac}_exp| <= TOL_ULP, computed as an unsigned WE+WF-bit difference.
- Result registration:
  - The compare result is registered.
  - On the next cycle, checked_count increments; on fail, err_count increments and mismatch pulses.
  - Counters saturate at all-ones.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start -> RUN; clear counters and the issue counter.
  - RUN: each accepted issue increments issue_cnt. When the N_OPS-th issue is accepted -> DRAIN on the next cycle. issue_valid is ignored once issue_cnt == N_OPS.
  - DRAIN: issue_valid is ignored. When all delay-line v bits are 0 and the compare register is empty -> DONE.
  - DONE: done=1 and pass=(err_count==0), both held. start -> RUN with counters cleared; done and pass drop the same cycle the start is registered.
- Boundary rules:
  - start while RUN or DRAIN: ignored.
  - issue_valid in IDLE or DONE: ignored; no count change.
  - Back-to-back issues every cycle: fully supported, no bubbles.
  - Gaps between issues: allowed; the delay line preserves spacing.
- Latency:
  - mismatch pulses at issue cycle + LATENCY + 1.
  - done rises exactly 2 cycles after the final tail compare.

Optional Feature:
- Macro: FMAC_CHECK_FIRSTERR_EN.
- Defined: adds three outputs, all cleared on start and reset:
  - first_err_idx (CNT_W): index of the first failed op.
  - first_err_r (WE+WF+3): r value of that op.
  - first_err_exp (WE+WF+3): expected value of that op.
  - Captured only on the first fail of a run.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Matching run. WE=8, WF=23, LATENCY=4, N_OPS=4. Issue 1.0 (34'h1_3F80_0000) four consecutive cycles; r returns the same values 4 cycles later -> checked_count=4, err_count=0, done=1, pass=1, mismatch never pulses.
- Single mismatch. Expected 1.0, r=2.0 (34'h1_4000_0000) on op 2 -> mismatch pulses at issue+5; err_count=1; pass=0; with FMAC_CHECK_FIRSTERR_EN, first_err_idx=2.
- Exceptions.
  - Expected zero 34'h0_0000_0000, r=34'h0_8000_0000 -> pass.
  - NaN 34'h3_0000_0001 vs 34'h3_FFFF_FFFF -> pass.
  - +inf vs -inf -> fail; err_count=1.
- Tolerance. TOL_ULP=1: expected 34'h1_3F80_0000, r=34'h1_3F7F_FFFF -> pass. r=34'h1_3F80_0002 -> fail.
- Flow control.
  - 6 issue_valid pulses with N_OPS=4 -> only 4 checked.
  - issue_valid pulses in IDLE -> counters stay 0.
  - start asserted during DRAIN -> ignored.
- Reset mid-DRAIN. Assert reset with 2 ops in flight -> next cycle busy=0, done=0, counts 0; no mismatch pulse afterwards.
